// File: rtl/simple_ppu_pkg.sv
// Shared PPU constants, framebuffer geometry and scanout types.
// Also holds the address helpers used by the scanout block and its line buffer.
package simple_ppu_pkg;

   localparam logic [23:0] FB_BASE_WORD   = 24'h04_0000;
   localparam int          VID_H_ACTIVE   = 320;
   localparam int          VID_V_ACTIVE   = 288;
   localparam int          WORDS_PER_LINE = 160;
   localparam int          MEM_RD_LATENCY = 2;

   localparam int          LB_DEPTH       = 2 * WORDS_PER_LINE;
   localparam int          LB_AW          = 9;
   localparam logic [15:0] RGB565_BLACK   = 16'h0000;

   typedef logic [8:0]       line_t;
   typedef logic [7:0]       word_t;
   typedef logic [LB_AW-1:0] lb_addr_t;
   typedef logic [15:0]      rgb565_t;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_REQ,
      FETCH_WAIT0,
      FETCH_WAIT1
   } fetch_state_e;

   // line*160 built from two shifts so no multiplier is inferred
   function automatic logic [23:0] fb_word_addr(line_t line, word_t word);
      return FB_BASE_WORD + 24'({line, 7'b0}) + 24'({line, 5'b0}) + 24'(word);
   endfunction

   function automatic lb_addr_t lb_addr(logic bank, word_t word);
      return bank ? lb_addr_t'(WORDS_PER_LINE) + lb_addr_t'(word) : lb_addr_t'(word);
   endfunction

endpackage

// File: rtl/simple_ppu_scanout_if.sv
// Word-read memory port between the scanout fetcher (master) and memory (slave).
interface simple_ppu_scanout_if;

   logic        mem_word_rd;
   logic [23:0] mem_word_addr;
   logic [31:0] mem_word_q;
   logic        mem_word_busy;

   modport master (
      output mem_word_rd,
      output mem_word_addr,
      input  mem_word_q,
      input  mem_word_busy
   );

   modport slave (
      input  mem_word_rd,
      input  mem_word_addr,
      output mem_word_q,
      output mem_word_busy
   );

endinterface

// File: rtl/simple_ppu_linebuf.sv
// Two-line scanout buffer: 320x32 simple dual-port RAM, registered read port.
module simple_ppu_linebuf
   import simple_ppu_pkg::*;
(
   input  logic        clk,
   input  logic        wr_en,
   input  lb_addr_t    wr_addr,
   input  logic [31:0] wr_data,
   input  logic        rd_en,
   input  lb_addr_t    rd_addr,
   output logic [31:0] rd_data
);

   logic [31:0] mem_q [0:LB_DEPTH-1];
   logic [31:0] rd_data_q;

   // Contents are deliberately not reset; ready bits guard every use.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/simple_ppu_scanout.sv
// Scanout fetcher: prefetches framebuffer lines into a two-bank line buffer
// and serves one RGB565 pixel per pix_req with a fixed 2-cycle latency.
module simple_ppu_scanout
   import simple_ppu_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        frame_start,
   input  logic                        pix_req,
   output logic                        pix_valid,
   output logic [15:0]                 pix_data,
   output logic                        underrun,
   simple_ppu_scanout_if.master        mem
);

   fetch_state_e     state_q, state_d;
   line_t            fetch_line_q, fetch_line_d;
   word_t            word_q, word_d;
   logic [23:0]      addr_q, addr_d;
   line_t            cons_line_q, cons_line_d;
   logic [8:0]       pix_cnt_q, pix_cnt_d;
   logic [1:0]       ready_q, ready_d;
   logic [1:0][8:0]  tag_q, tag_d;
   logic             underrun_q, underrun_d;
   logic             vld_p1_q, vld_p1_d;
   logic             hit_p1_q, hit_p1_d;
   logic             odd_p1_q, odd_p1_d;
   logic             pix_valid_q, pix_valid_d;
   rgb565_t          pix_data_q, pix_data_d;

   logic             fetch_bank;
   logic             cons_bank;
   line_t            eff_line;
   logic             start_ok;
   logic             cons_live;
   logic             hit;
   logic             last_word;
   logic             rd_fire;
   logic             lb_wr_en;
   lb_addr_t         lb_wr_addr;
   lb_addr_t         lb_rd_addr;
   logic [31:0]      lb_rd_data;

   assign fetch_bank = fetch_line_q[0];
   assign cons_bank  = cons_line_q[0];
   // A fetcher that fell behind the consumer jumps straight to the live line
   assign eff_line   = (fetch_line_q < cons_line_q) ? cons_line_q : fetch_line_q;
   assign start_ok   = enable
                       && (eff_line < line_t'(VID_V_ACTIVE))
                       && ({1'b0, eff_line} <= ({1'b0, cons_line_q} + 10'd1))
                       && !ready_q[eff_line[0]];
   assign cons_live  = cons_line_q < line_t'(VID_V_ACTIVE);
   assign hit        = cons_live && ready_q[cons_bank]
                       && (tag_q[cons_bank] == cons_line_q) && !frame_start;
   assign last_word  = word_q == word_t'(WORDS_PER_LINE - 1);

   assign rd_fire    = (state_q == FETCH_REQ) && !mem.mem_word_busy && enable
                       && !frame_start && !reset;
   assign lb_wr_en   = (state_q == FETCH_WAIT1) && !frame_start && !reset;
   assign lb_wr_addr = lb_addr(fetch_bank, word_q);
   assign lb_rd_addr = lb_addr(cons_bank, pix_cnt_q[8:1]);

   assign mem.mem_word_rd   = rd_fire;
   assign mem.mem_word_addr = addr_q;
   assign pix_valid         = pix_valid_q;
   assign pix_data          = pix_data_q;
   assign underrun          = underrun_q;

   simple_ppu_linebuf u_linebuf (
      .clk     (clk),
      .wr_en   (lb_wr_en),
      .wr_addr (lb_wr_addr),
      .wr_data (mem.mem_word_q),
      .rd_en   (pix_req),
      .rd_addr (lb_rd_addr),
      .rd_data (lb_rd_data)
   );

   always_comb begin
      state_d      = state_q;
      fetch_line_d = fetch_line_q;
      word_d       = word_q;
      addr_d       = addr_q;
      cons_line_d  = cons_line_q;
      pix_cnt_d    = pix_cnt_q;
      ready_d      = ready_q;
      tag_d        = tag_q;
      underrun_d   = underrun_q;
      vld_p1_d     = pix_req;
      hit_p1_d     = hit;
      odd_p1_d     = pix_cnt_q[0];
      pix_valid_d  = vld_p1_q;
      pix_data_d   = pix_data_q;

      // stage p2: select the half-word out of the registered buffer word
      if (vld_p1_q) begin
         if (hit_p1_q) begin
            pix_data_d = odd_p1_q ? lb_rd_data[31:16] : lb_rd_data[15:0];
         end else begin
            pix_data_d = RGB565_BLACK;
         end
      end

      case (state_q)
         FETCH_IDLE: begin
            if (start_ok) begin
               state_d      = FETCH_REQ;
               fetch_line_d = eff_line;
               word_d       = '0;
               addr_d       = fb_word_addr(eff_line, '0);
            end
         end
         FETCH_REQ: begin
            if (rd_fire) begin
               state_d = FETCH_WAIT0;
            end
         end
         FETCH_WAIT0: begin
            state_d = FETCH_WAIT1;
         end
         FETCH_WAIT1: begin
            if (last_word) begin
               state_d             = FETCH_IDLE;
               ready_d[fetch_bank] = 1'b1;
               tag_d[fetch_bank]   = fetch_line_q;
               fetch_line_d        = fetch_line_q + line_t'(1);
            end else begin
               state_d = FETCH_REQ;
               word_d  = word_q + word_t'(1);
               addr_d  = addr_q + 24'd1;
            end
         end
         default: state_d = FETCH_IDLE;
      endcase

      // Consumer side comes after the fetcher so a line-end clear wins a tie
      if (pix_req) begin
         if (!hit && cons_live) begin
            underrun_d = 1'b1;
         end
         if (pix_cnt_q == 9'(VID_H_ACTIVE - 1)) begin
            pix_cnt_d          = '0;
            ready_d[cons_bank] = 1'b0;
            if (cons_live) begin
               cons_line_d = cons_line_q + line_t'(1);
            end
         end else begin
            pix_cnt_d = pix_cnt_q + 9'd1;
         end
      end

      if (frame_start) begin
         state_d      = FETCH_IDLE;
         ready_d      = '0;
         underrun_d   = 1'b0;
         cons_line_d  = '0;
         fetch_line_d = '0;
         pix_cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FETCH_IDLE;
         fetch_line_q <= '0;
         word_q       <= '0;
         addr_q       <= '0;
         cons_line_q  <= '0;
         pix_cnt_q    <= '0;
         ready_q      <= '0;
         underrun_q   <= 1'b0;
         vld_p1_q     <= 1'b0;
         hit_p1_q     <= 1'b0;
         pix_valid_q  <= 1'b0;
         pix_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         fetch_line_q <= fetch_line_d;
         word_q       <= word_d;
         addr_q       <= addr_d;
         cons_line_q  <= cons_line_d;
         pix_cnt_q    <= pix_cnt_d;
         ready_q      <= ready_d;
         underrun_q   <= underrun_d;
         vld_p1_q     <= vld_p1_d;
         hit_p1_q     <= hit_p1_d;
         pix_valid_q  <= pix_valid_d;
         pix_data_q   <= pix_data_d;
      end
   end

   // Tags and the half-word select only matter once qualified by control state
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      odd_p1_q <= odd_p1_d;
   end

endmodule

// File: tb/tb_simple_ppu_scanout.sv
// Directed bench for simple_ppu_scanout with a 2-cycle-latency word memory model.
module tb_simple_ppu_scanout;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        frame_start;
   logic        pix_req;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic        underrun;

   simple_ppu_scanout_if mem_if ();

   simple_ppu_scanout dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .frame_start (frame_start),
      .pix_req     (pix_req),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .underrun    (underrun),
      .mem         (mem_if)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_fail = 0;
   int          rd_count = 0;
   int          busy_rd = 0;
   bit          have_prev = 1'b0;
   logic [23:0] last_rd_addr = '0;

   // Framebuffer contents as a function of word address
   function automatic logic [31:0] mem_f(logic [23:0] a);
      if (a == 24'h04_0000) return 32'hBBBB_AAAA;
      return {a[15:0] ^ 16'hC3C3, a[15:0] + 16'h1111};
   endfunction

   function automatic logic [15:0] exp_pix(int line, int p);
      logic [23:0] a;
      logic [31:0] w;
      a = 24'h04_0000 + 24'(line * 160 + p / 2);
      w = mem_f(a);
      return (p % 2 == 1) ? w[31:16] : w[15:0];
   endfunction

   logic        mv1 = 1'b0;
   logic [23:0] ma1 = '0;
   always @(posedge clk) begin
      mv1 <= mem_if.mem_word_rd;
      ma1 <= mem_if.mem_word_addr;
      mem_if.mem_word_q <= mv1 ? mem_f(ma1) : 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (mem_if.mem_word_rd === 1'b1) begin
         if (have_prev) chk("rd_addr_contig", 32'(mem_if.mem_word_addr), 32'(last_rd_addr + 24'd1));
         if (mem_if.mem_word_busy) busy_rd++;
         last_rd_addr = mem_if.mem_word_addr;
         have_prev = 1'b1;
         rd_count++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      have_prev = 1'b0;
   endtask

   task automatic wait_reads(input int target, input int budget, input string name);
      for (int i = 0; i < budget && rd_count < target; i++) tick();
      chk(name, 32'(rd_count >= target), 32'd1);
   endtask

   typedef struct {
      bit          fs;
      int          gap;
      logic [15:0] exp_data;
      bit          exp_un;
   } vec_t;

   vec_t vt [9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int base;
      int mark;

      vt[0] = '{1'b0, 0, 16'hAAAA, 1'b0};
      vt[1] = '{1'b0, 0, 16'hBBBB, 1'b0};
      vt[2] = '{1'b0, 2, 16'h1112, 1'b0};
      vt[3] = '{1'b0, 0, 16'hC3C2, 1'b0};
      vt[4] = '{1'b0, 5, 16'h1113, 1'b0};
      vt[5] = '{1'b0, 1, 16'hC3C1, 1'b0};
      vt[6] = '{1'b1, 0, 16'h0000, 1'b0};
      vt[7] = '{1'b0, 0, 16'h0000, 1'b1};
      vt[8] = '{1'b0, 3, 16'h0000, 1'b1};

      reset = 1'b1;
      enable = 1'b0;
      frame_start = 1'b0;
      pix_req = 1'b0;
      mem_if.mem_word_busy = 1'b0;
      repeat (3) tick();
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_pix_data", 32'(pix_data), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_mem_rd", 32'(mem_if.mem_word_rd), 32'd0);
      chk("rst_mem_addr", 32'(mem_if.mem_word_addr), 32'd0);
      reset = 1'b0;
      tick();

      // enable low holds the fetcher off; raising it starts at the frame base
      pulse_fs();
      repeat (20) tick();
      chk("no_rd_disabled", 32'(rd_count), 32'd0);
      enable = 1'b1;
      tick();
      tick();
      chk("enable_start_cnt", 32'(rd_count), 32'd1);
      chk("enable_start_addr", 32'(last_rd_addr), 32'h04_0000);

      // busy window mid-line
      repeat (20) tick();
      mem_if.mem_word_busy = 1'b1;
      repeat (10) tick();
      mem_if.mem_word_busy = 1'b0;
      chk("no_rd_while_busy", 32'(busy_rd), 32'd0);
      mark = rd_count;
      repeat (6) tick();
      chk("rd_resume", 32'(rd_count > mark), 32'd1);

      wait_reads(320, 1500, "fill_two_lines");
      repeat (10) tick();
      chk("prefetch_limit", 32'(rd_count), 32'd320);

      for (int i = 0; i < 9; i++) begin
         repeat (vt[i].gap) tick();
         pix_req = 1'b1;
         frame_start = vt[i].fs;
         tick();
         pix_req = 1'b0;
         frame_start = 1'b0;
         if (vt[i].fs) have_prev = 1'b0;
         chk($sformatf("vec%0d_valid_early", i), 32'(pix_valid), 32'd0);
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(pix_valid), 32'd1);
         chk($sformatf("vec%0d_data", i), 32'(pix_data), 32'(vt[i].exp_data));
         chk($sformatf("vec%0d_underrun", i), 32'(underrun), 32'(vt[i].exp_un));
      end

      repeat (600) tick();
      chk("underrun_sticky", 32'(underrun), 32'd1);
      pulse_fs();
      chk("underrun_cleared", 32'(underrun), 32'd0);
      base = rd_count;

      wait_reads(base + 320, 1500, "refill_two_lines");
      repeat (5) tick();

      // four lines at one pixel per four cycles with every pixel checked
      for (int l = 0; l < 4; l++) begin
         for (int p = 0; p < 320; p++) begin
            pix_req = 1'b1;
            tick();
            pix_req = 1'b0;
            tick();
            chk($sformatf("scan_valid_l%0d_p%0d", l, p), 32'(pix_valid), 32'd1);
            chk($sformatf("scan_data_l%0d_p%0d", l, p), 32'(pix_data), 32'(exp_pix(l, p)));
            tick();
            tick();
         end
      end
      chk("scan_no_underrun", 32'(underrun), 32'd0);

      // abort a line-5 fetch in its first wait state
      for (int i = 0; i < 1500 && last_rd_addr != 24'h04_0320; i++) tick();
      chk("line5_reached", 32'(last_rd_addr), 32'h04_0320);
      chk("reads_before_line5", 32'(rd_count - base), 32'd801);
      pulse_fs();
      mark = rd_count;
      for (int i = 0; i < 6 && rd_count == mark; i++) tick();
      chk("restart_seen", 32'(rd_count > mark), 32'd1);
      chk("restart_addr", 32'(last_rd_addr), 32'h04_0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
